mem_stage: RTL and testbench

- Memory-access stage of the 5-stage RV64 pipeline, between execute and writeback.
- Consumes one exec_data_t bundle plus store data per instruction.
- Loads and stores perform a valid/data_ok handshake on the data bus and hold the upstream stages with stall_o until the access completes.
- Results are registered into a mem_data_t bundle for writeback, and a fwd_data_t bundle is driven from that register for operand forwarding.

---
 rtl/mem_stage.sv | 230 +++++++++++++++++++++++
 tb/tb_mem_stage.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
//==============================================================================
// Module      : mem_stage (with mem_stage_pkg)
// Description : Memory-access stage of the 5-stage RV64 pipeline. Passes
//               non-memory instructions straight to writeback. Runs a
//               valid/data_ok handshake on the data bus for loads and stores,
//               and stalls upstream until the access completes.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package mem_stage_pkg;

    typedef logic [63:0] word_t;

    // 96 bits
    typedef struct packed {
        word_t       pc;
        logic [31:0] raw_instr;
    } instr_t;

    // 17 bits
    typedef struct packed {
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       branch;
        logic       jump;
        logic       alu_src;
        logic       is_word;
        logic [8:0] alu_op;
    } ctl_t;

    // 182 bits
    typedef struct packed {
        instr_t     instr;
        ctl_t       ctl;
        logic [4:0] dst;
        word_t      aluout;
    } exec_data_t;

    // 182 bits
    typedef struct packed {
        instr_t     instr;
        ctl_t       ctl;
        logic [4:0] dst;
        word_t      writedata;
    } mem_data_t;

    // 70 bits
    typedef struct packed {
        logic       valid;
        logic [4:0] dst;
        word_t      data;
    } fwd_data_t;

endpackage

module mem_stage
    import mem_stage_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    input  logic           in_valid,
    input  logic [181:0]   in_data,
    input  logic [63:0]    in_storedata,
    output logic           stall_o,
    output logic           dreq_valid,
    output logic [63:0]    dreq_addr,
    output logic [2:0]     dreq_size,
    output logic [7:0]     dreq_strobe,
    output logic [63:0]    dreq_data,
    input  logic           dresp_data_ok,
    input  logic [63:0]    dresp_data,
    output logic           out_valid,
    output logic [181:0]   out_data,
    output logic [69:0]    fwd_o
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t     r_state;
    logic       r_out_valid;
    mem_data_t  r_out;

    // Request registers: held constant for the whole WAIT phase
    logic       r_dreq_valid;
    logic [63:0] r_addr;
    logic [2:0] r_size;
    logic [7:0] r_strobe;
    logic [63:0] r_wdata;
    logic [2:0] r_f3;
    logic       r_is_load;

    exec_data_t w_in;
    logic       w_memop;
    logic [2:0] w_f3;
    logic [2:0] w_lane;
    logic [7:0] w_strobe;
    logic [63:0] w_wdata;
    logic [63:0] w_raw;
    logic [63:0] w_ext;
    fwd_data_t  w_fwd;

    assign w_in    = in_data;
    assign w_memop = w_in.ctl.mem_read | w_in.ctl.mem_write;
    assign w_f3    = w_in.instr.raw_instr[14:12];
    assign w_lane  = w_in.aluout[2:0];

    // Store byte-lane mask and lane-aligned data; bytes shifted past lane 7 fall off
    always_comb begin
        w_strobe = 8'h00;
        if (w_in.ctl.mem_write) begin
            case (w_f3[1:0])
                2'd0:    w_strobe = 8'h01 << w_lane;
                2'd1:    w_strobe = 8'h03 << w_lane;
                2'd2:    w_strobe = 8'h0F << w_lane;
                default: w_strobe = 8'hFF << w_lane;
            endcase
        end
    end

    assign w_wdata = in_storedata << {w_lane, 3'b000};

    // Load extraction from the 8-byte-aligned response using the latched lane and funct3
    assign w_raw = dresp_data >> {r_addr[2:0], 3'b000};

    always_comb begin
        w_ext = 64'd0;
        case (r_f3)
            3'b000:  w_ext = {{56{w_raw[7]}},  w_raw[7:0]};
            3'b001:  w_ext = {{48{w_raw[15]}}, w_raw[15:0]};
            3'b010:  w_ext = {{32{w_raw[31]}}, w_raw[31:0]};
            3'b011:  w_ext = w_raw;
            3'b100:  w_ext = {56'd0, w_raw[7:0]};
            3'b101:  w_ext = {48'd0, w_raw[15:0]};
            3'b110:  w_ext = {32'd0, w_raw[31:0]};
            default: w_ext = 64'd0;
        endcase
    end

    // Hold upstream while a memory access is being issued or is still outstanding
    always_comb begin
        stall_o = 1'b0;
        case (r_state)
            S_IDLE:  stall_o = in_valid & w_memop;
            S_WAIT:  stall_o = ~dresp_data_ok;
            default: stall_o = 1'b0;
        endcase
    end

    // Stage FSM: captures passthrough results, launches requests, retires responses
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_out_valid  <= 1'b0;
            r_out        <= '0;
            r_dreq_valid <= 1'b0;
            r_addr       <= 64'd0;
            r_size       <= 3'd0;
            r_strobe     <= 8'd0;
            r_wdata      <= 64'd0;
            r_f3         <= 3'd0;
            r_is_load    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid && !w_memop) begin
                        r_out.instr     <= w_in.instr;
                        r_out.ctl       <= w_in.ctl;
                        r_out.dst       <= w_in.dst;
                        r_out.writedata <= w_in.aluout;
                        r_out_valid     <= 1'b1;
                    end else if (in_valid && w_memop) begin
                        r_addr       <= w_in.aluout;
                        r_size       <= {1'b0, w_f3[1:0]};
                        r_strobe     <= w_strobe;
                        r_wdata      <= w_wdata;
                        r_f3         <= w_f3;
                        r_is_load    <= w_in.ctl.mem_read;
                        r_dreq_valid <= 1'b1;
                        r_out_valid  <= 1'b0;
                        r_state      <= S_WAIT;
                    end else begin
                        r_out_valid <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (dresp_data_ok) begin
                        r_out.instr     <= w_in.instr;
                        r_out.ctl       <= w_in.ctl;
                        r_out.dst       <= w_in.dst;
                        r_out.writedata <= r_is_load ? w_ext : w_in.aluout;
                        r_out_valid     <= 1'b1;
                        r_dreq_valid    <= 1'b0;
                        r_state         <= S_IDLE;
                    end else begin
                        r_out_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state      <= S_IDLE;
                    r_dreq_valid <= 1'b0;
                    r_out_valid  <= 1'b0;
                end
            endcase
        end
    end

    assign dreq_valid  = r_dreq_valid;
    assign dreq_addr   = r_addr;
    assign dreq_size   = r_size;
    assign dreq_strobe = r_strobe;
    assign dreq_data   = r_wdata;

    assign out_valid = r_out_valid;
    assign out_data  = r_out;

    // Forward only results that will actually write a non-zero register
    assign w_fwd.valid = r_out_valid & r_out.ctl.reg_write & (r_out.dst != 5'd0);
    assign w_fwd.dst   = r_out.dst;
    assign w_fwd.data  = r_out.writedata;
    assign fwd_o       = w_fwd;

endmodule

`default_nettype wire

// File: tb/tb_mem_stage.sv
//==============================================================================
// Module      : tb_mem_stage
// Description : Directed self-checking bench for mem_stage.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_mem_stage;
    import mem_stage_pkg::*;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic [181:0] in_data;
    logic [63:0]  in_storedata;
    logic         stall_o;
    logic         dreq_valid;
    logic [63:0]  dreq_addr;
    logic [2:0]   dreq_size;
    logic [7:0]   dreq_strobe;
    logic [63:0]  dreq_data;
    logic         dresp_data_ok;
    logic [63:0]  dresp_data;
    logic         out_valid;
    logic [181:0] out_data;
    logic [69:0]  fwd_o;

    int n_checks = 0;
    int n_fail   = 0;

    mem_data_t o;
    fwd_data_t f;
    assign o = out_data;
    assign f = fwd_o;

    mem_stage dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_data       (in_data),
        .in_storedata  (in_storedata),
        .stall_o       (stall_o),
        .dreq_valid    (dreq_valid),
        .dreq_addr     (dreq_addr),
        .dreq_size     (dreq_size),
        .dreq_strobe   (dreq_strobe),
        .dreq_data     (dreq_data),
        .dresp_data_ok (dresp_data_ok),
        .dresp_data    (dresp_data),
        .out_valid     (out_valid),
        .out_data      (out_data),
        .fwd_o         (fwd_o)
    );

    always #5 clk = ~clk;

    function automatic exec_data_t mk_in(input logic [2:0] f3, input logic rw,
                                         input logic mr, input logic mw, input logic m2r,
                                         input logic [4:0] dst, input logic [63:0] alu);
        exec_data_t e;
        e = '0;
        e.instr.pc            = 64'h8000_0000;
        e.instr.raw_instr     = {17'd0, f3, 5'd0, 7'h03};
        e.ctl.reg_write       = rw;
        e.ctl.mem_read        = mr;
        e.ctl.mem_write       = mw;
        e.ctl.mem_to_reg      = m2r;
        e.dst                 = dst;
        e.aluout              = alu;
        return e;
    endfunction

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; in_data = '0; in_storedata = 64'd0;
        dresp_data_ok = 1'b0; dresp_data = 64'd0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        n_checks++; if (out_data !== 182'd0) begin n_fail++; $display("FAIL reset_out_data: got %h expected 0", out_data); end
        n_checks++; if (dreq_valid !== 1'b0) begin n_fail++; $display("FAIL reset_dreq_valid: got %b expected 0", dreq_valid); end
        n_checks++; if (fwd_o !== 70'd0) begin n_fail++; $display("FAIL reset_fwd: got %h expected 0", fwd_o); end
        n_checks++; if (stall_o !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b expected 0", stall_o); end
        reset = 1'b0;
    endtask

    task automatic test_add();
        @(posedge clk); #1;
        in_valid = 1'b1; in_data = mk_in(3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 5'd3, 64'h5);
        #1;
        n_checks++; if (stall_o !== 1'b0) begin n_fail++; $display("FAIL add_stall: got %b expected 0", stall_o); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL add_out_valid: got %b expected 1", out_valid); end
        n_checks++; if (o.writedata !== 64'h5) begin n_fail++; $display("FAIL add_writedata: got %h expected 5", o.writedata); end
        n_checks++; if (fwd_o !== {1'b1, 5'd3, 64'h5}) begin n_fail++; $display("FAIL add_fwd: got %h expected %h", fwd_o, {1'b1, 5'd3, 64'h5}); end
        n_checks++; if (stall_o !== 1'b0) begin n_fail++; $display("FAIL add_stall2: got %b expected 0", stall_o); end
        @(posedge clk); #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL add_idle_out_valid: got %b expected 0", out_valid); end
    endtask

    task automatic test_lb();
        @(posedge clk); #1;
        in_valid = 1'b1; in_data = mk_in(3'b000, 1'b1, 1'b1, 1'b0, 1'b1, 5'd5, 64'h8000_0003);
        #1;
        n_checks++; if (stall_o !== 1'b1) begin n_fail++; $display("FAIL lb_stall_idle: got %b expected 1", stall_o); end
        n_checks++; if (dreq_valid !== 1'b0) begin n_fail++; $display("FAIL lb_dreq_idle: got %b expected 0", dreq_valid); end
        @(posedge clk); #1;
        dresp_data_ok = 1'b1; dresp_data = 64'h0000_0000_8000_0000;
        #1;
        n_checks++; if (dreq_valid !== 1'b1) begin n_fail++; $display("FAIL lb_dreq_valid: got %b expected 1", dreq_valid); end
        n_checks++; if (dreq_addr !== 64'h8000_0003) begin n_fail++; $display("FAIL lb_addr: got %h expected 80000003", dreq_addr); end
        n_checks++; if (dreq_size !== 3'd0 || dreq_strobe !== 8'h00) begin n_fail++; $display("FAIL lb_size_strobe: got %0d/%h expected 0/00", dreq_size, dreq_strobe); end
        n_checks++; if (stall_o !== 1'b0) begin n_fail++; $display("FAIL lb_stall_ok: got %b expected 0", stall_o); end
        @(posedge clk); #1;
        dresp_data_ok = 1'b0; in_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL lb_out_valid: got %b expected 1", out_valid); end
        n_checks++; if (o.writedata !== 64'hFFFF_FFFF_FFFF_FF80) begin n_fail++; $display("FAIL lb_writedata: got %h expected ffffffffffffff80", o.writedata); end
        n_checks++; if (dreq_valid !== 1'b0) begin n_fail++; $display("FAIL lb_dreq_drop: got %b expected 0", dreq_valid); end
        n_checks++; if (f.valid !== 1'b1 || f.dst !== 5'd5) begin n_fail++; $display("FAIL lb_fwd: got %b/%0d expected 1/5", f.valid, f.dst); end
    endtask

    task automatic test_lh();
        @(posedge clk); #1;
        in_valid = 1'b1; in_data = mk_in(3'b001, 1'b1, 1'b1, 1'b0, 1'b1, 5'd8, 64'h8000_0002);
        @(posedge clk); #1;
        dresp_data_ok = 1'b1; dresp_data = 64'h0000_0000_8001_0000;
        @(posedge clk); #1;
        dresp_data_ok = 1'b0; in_valid = 1'b0;
        n_checks++; if (o.writedata !== 64'hFFFF_FFFF_FFFF_8001) begin n_fail++; $display("FAIL lh_writedata: got %h expected ffffffffffff8001", o.writedata); end
    endtask

    task automatic test_lwu();
        @(posedge clk); #1;
        in_valid = 1'b1; in_data = mk_in(3'b110, 1'b1, 1'b1, 1'b0, 1'b1, 5'd6, 64'h8000_0004);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            n_checks++; if (dreq_valid !== 1'b1 || dreq_addr !== 64'h8000_0004 || dreq_size !== 3'd2 || dreq_strobe !== 8'h00)
                begin n_fail++; $display("FAIL lwu_dreq_hold[%0d]: got %b/%h/%0d/%h expected 1/80000004/2/00", i, dreq_valid, dreq_addr, dreq_size, dreq_strobe); end
            n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL lwu_out_early[%0d]: got %b expected 0", i, out_valid); end
            if (i == 3) begin
                dresp_data_ok = 1'b1; dresp_data = 64'hF000_0000_0000_0000;
            end
            #1;
            n_checks++; if (stall_o !== (i != 3)) begin n_fail++; $display("FAIL lwu_stall[%0d]: got %b expected %b", i, stall_o, (i != 3)); end
        end
        @(posedge clk); #1;
        dresp_data_ok = 1'b0; in_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL lwu_out_valid: got %b expected 1", out_valid); end
        n_checks++; if (o.writedata !== 64'h0000_0000_F000_0000) begin n_fail++; $display("FAIL lwu_writedata: got %h expected 00000000f0000000", o.writedata); end
    endtask

    task automatic test_sh();
        @(posedge clk); #1;
        in_valid = 1'b1; in_storedata = 64'h1234;
        in_data = mk_in(3'b001, 1'b0, 1'b0, 1'b1, 1'b0, 5'd7, 64'h8000_0006);
        @(posedge clk); #1;
        n_checks++; if (dreq_strobe !== 8'hC0) begin n_fail++; $display("FAIL sh_strobe: got %h expected c0", dreq_strobe); end
        n_checks++; if (dreq_data !== 64'h1234_0000_0000_0000) begin n_fail++; $display("FAIL sh_data: got %h expected 1234000000000000", dreq_data); end
        n_checks++; if (dreq_size !== 3'd1 || dreq_valid !== 1'b1) begin n_fail++; $display("FAIL sh_size_valid: got %0d/%b expected 1/1", dreq_size, dreq_valid); end
        dresp_data_ok = 1'b1; dresp_data = 64'hDEAD_BEEF_DEAD_BEEF;
        @(posedge clk); #1;
        dresp_data_ok = 1'b0; in_valid = 1'b0; in_storedata = 64'd0;
        n_checks++; if (out_valid !== 1'b1 || o.ctl.reg_write !== 1'b0) begin n_fail++; $display("FAIL sh_out: got %b/%b expected 1/0", out_valid, o.ctl.reg_write); end
        n_checks++; if (o.writedata !== 64'h8000_0006) begin n_fail++; $display("FAIL sh_writedata: got %h expected 80000006", o.writedata); end
        n_checks++; if (f.valid !== 1'b0) begin n_fail++; $display("FAIL sh_fwd_valid: got %b expected 0", f.valid); end
    endtask

    task automatic test_reset_wait();
        @(posedge clk); #1;
        in_valid = 1'b1; in_data = mk_in(3'b011, 1'b1, 1'b1, 1'b0, 1'b1, 5'd9, 64'h8000_0010);
        @(posedge clk); #1;
        n_checks++; if (dreq_valid !== 1'b1) begin n_fail++; $display("FAIL rstw_dreq_pre: got %b expected 1", dreq_valid); end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; in_valid = 1'b0;
        #1;
        n_checks++; if (dreq_valid !== 1'b0) begin n_fail++; $display("FAIL rstw_dreq: got %b expected 0", dreq_valid); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstw_out_valid: got %b expected 0", out_valid); end
        n_checks++; if (stall_o !== 1'b0) begin n_fail++; $display("FAIL rstw_stall: got %b expected 0", stall_o); end
        dresp_data_ok = 1'b1; dresp_data = 64'h1111_2222_3333_4444;
        @(posedge clk); #1;
        dresp_data_ok = 1'b0;
        n_checks++; if (out_valid !== 1'b0 || dreq_valid !== 1'b0) begin n_fail++; $display("FAIL rstw_late_ok: got %b/%b expected 0/0", out_valid, dreq_valid); end
        @(posedge clk); #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstw_late_ok2: got %b expected 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        @(posedge clk); #1;
        in_valid = 1'b1; in_data = mk_in(3'b011, 1'b1, 1'b1, 1'b0, 1'b1, 5'd10, 64'h8000_0020);
        #1;
        n_checks++; if (stall_o !== 1'b1) begin n_fail++; $display("FAIL b2b_stall0: got %b expected 1", stall_o); end
        @(posedge clk); #1;
        dresp_data_ok = 1'b1; dresp_data = 64'h1122_3344_5566_7788;
        #1;
        n_checks++; if (stall_o !== 1'b0) begin n_fail++; $display("FAIL b2b_stall1: got %b expected 0", stall_o); end
        @(posedge clk); #1;
        dresp_data_ok = 1'b0;
        in_data = mk_in(3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 5'd11, 64'h2A);
        n_checks++; if (out_valid !== 1'b1 || o.dst !== 5'd10) begin n_fail++; $display("FAIL b2b_ld_out: got %b/%0d expected 1/10", out_valid, o.dst); end
        n_checks++; if (o.writedata !== 64'h1122_3344_5566_7788) begin n_fail++; $display("FAIL b2b_ld_data: got %h expected 1122334455667788", o.writedata); end
        #1;
        n_checks++; if (stall_o !== 1'b0) begin n_fail++; $display("FAIL b2b_stall2: got %b expected 0", stall_o); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b1 || o.dst !== 5'd11 || o.writedata !== 64'h2A) begin n_fail++; $display("FAIL b2b_addi_out: got %b/%0d/%h expected 1/11/2a", out_valid, o.dst, o.writedata); end
        n_checks++; if (fwd_o !== {1'b1, 5'd11, 64'h2A}) begin n_fail++; $display("FAIL b2b_fwd: got %h expected %h", fwd_o, {1'b1, 5'd11, 64'h2A}); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_lb();
        test_lh();
        test_lwu();
        test_sh();
        test_reset_wait();
        test_back_to_back();
        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
